// File: rtl/motion_pkg.sv
// Shared types and defaults for the motion frame accumulator.
package motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_FRAME_W      = 640;
    localparam int DEF_FRAME_H      = 480;
    localparam int DEF_CNT_W        = 19;
    localparam int DEF_ALARM_FRAMES = 3;

    // Bit width able to index n items; never below 1.
    function automatic int pos_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster position tracker: x/y of the pixel presented this cycle and the
// flag marking the final pixel of the frame.
module pixel_pos_counter
    import motion_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    localparam int XW = pos_w(FRAME_W),
    localparam int YW = pos_w(FRAME_H)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          adv,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          last
);
    localparam logic [XW-1:0] X_MAX = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FRAME_H - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // A start pixel sits at the origin no matter where the old frame stopped.
    assign cur_x = start ? '0 : x_q;
    assign cur_y = start ? '0 : y_q;
    assign last  = (cur_x == X_MAX) && (cur_y == Y_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (start || adv) begin
            if (cur_x == X_MAX) begin
                x_q <= '0;
                y_q <= (cur_y == Y_MAX) ? '0 : cur_y + 1'b1;
            end else begin
                x_q <= cur_x + 1'b1;
                y_q <= cur_y;
            end
        end
    end

endmodule

// File: rtl/motion_frame_accum.sv
// Per-frame motion pixel accumulator with hysteretic multi-frame alarm.
// Optional region of interest enabled by defining MOTION_ROI_EN.
module motion_frame_accum
    import motion_pkg::*;
#(
    parameter int FRAME_W      = DEF_FRAME_W,
    parameter int FRAME_H      = DEF_FRAME_H,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int ALARM_FRAMES = DEF_ALARM_FRAMES,
    localparam int XW = pos_w(FRAME_W),
    localparam int YW = pos_w(FRAME_H)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sof,
    input  logic             motion_detected,
    input  logic [CNT_W-1:0] threshold,
`ifdef MOTION_ROI_EN
    input  logic [XW-1:0]    roi_x0,
    input  logic [XW-1:0]    roi_x1,
    input  logic [YW-1:0]    roi_y0,
    input  logic [YW-1:0]    roi_y1,
`endif
    output logic [CNT_W-1:0] motion_count,
    output logic             count_valid,
    output logic             motion_alarm,
    output logic             frame_err
);
    localparam int AW = pos_w(ALARM_FRAMES + 1);
    localparam logic [AW-1:0] STREAK_MAX = AW'(ALARM_FRAMES);

    state_t state_q, state_d;

    logic             start, adv, pix, last, done, in_roi, counted;
    logic             active, quiet;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic [CNT_W-1:0] acc_q, acc_base, acc_next, thr_q, thr_cur;
    logic [AW-1:0]    streak_q, streak_next;

    // sof with enable restarts a frame from any state.
    assign start = enable && sof;
    assign adv   = enable && !sof && (state_q == ACCUM);
    assign pix   = start || adv;
    assign done  = pix && last;

    pixel_pos_counter #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H)
    ) u_pos (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .adv   (adv),
        .cur_x (cur_x),
        .cur_y (cur_y),
        .last  (last)
    );

`ifdef MOTION_ROI_EN
    logic [XW-1:0] rx0_q, rx1_q, rx0, rx1;
    logic [YW-1:0] ry0_q, ry1_q, ry0, ry1;

    // The start pixel must see the window being sampled alongside it.
    assign rx0 = start ? roi_x0 : rx0_q;
    assign rx1 = start ? roi_x1 : rx1_q;
    assign ry0 = start ? roi_y0 : ry0_q;
    assign ry1 = start ? roi_y1 : ry1_q;
    assign in_roi = (cur_x >= rx0) && (cur_x <= rx1) &&
                    (cur_y >= ry0) && (cur_y <= ry1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx0_q <= '0;
            rx1_q <= '0;
            ry0_q <= '0;
            ry1_q <= '0;
        end else if (start) begin
            rx0_q <= roi_x0;
            rx1_q <= roi_x1;
            ry0_q <= roi_y0;
            ry1_q <= roi_y1;
        end
    end
`else
    logic pos_unused;
    assign pos_unused = ^{cur_x, cur_y};
    assign in_roi     = 1'b1;
`endif

    assign counted  = pix && in_roi && motion_detected;
    assign acc_base = start ? '0 : acc_q;
    assign acc_next = (counted && !(&acc_base)) ? acc_base + 1'b1 : acc_base;
    assign thr_cur  = start ? threshold : thr_q;

    // Counts between thr>>1 and thr-1 are neither: alarm holds its level.
    assign active      = acc_next >= thr_cur;
    assign quiet       = acc_next < (thr_cur >> 1);
    assign streak_next = !active ? '0 :
                         (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = done ? REPORT : ACCUM;
            ACCUM:   if (pix)   state_d = done ? REPORT : ACCUM;
            REPORT:  state_d = start ? (done ? REPORT : ACCUM) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            thr_q        <= '0;
            streak_q     <= '0;
            motion_count <= '0;
            count_valid  <= 1'b0;
            motion_alarm <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            count_valid <= done;
            frame_err   <= start && (state_q != IDLE);
            if (pix)   acc_q <= acc_next;
            if (start) thr_q <= threshold;
            if (done) begin
                motion_count <= acc_next;
                streak_q     <= streak_next;
                if (streak_next == STREAK_MAX) motion_alarm <= 1'b1;
                else if (quiet)                motion_alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_motion_frame_accum.sv
// Directed bench for motion_frame_accum (8x4 frame, threshold 10) with a
// frame-level reference model checked every cycle.
module tb_motion_frame_accum;
    localparam int W = 8, H = 4, CW = 6, AF = 3, NPIX = W * H;

    logic          clk = 1'b0, rst = 1'b1;
    logic          enable = 1'b0, sof = 1'b0, motion_detected = 1'b0;
    logic [CW-1:0] threshold = 6'd10;
`ifdef MOTION_ROI_EN
    logic [2:0]    roi_x0 = 3'd0, roi_x1 = 3'd7;
    logic [1:0]    roi_y0 = 2'd0, roi_y1 = 2'd3;
`endif
    logic [CW-1:0] motion_count;
    logic          count_valid, motion_alarm, frame_err;

    motion_frame_accum #(
        .FRAME_W(W), .FRAME_H(H), .CNT_W(CW), .ALARM_FRAMES(AF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sof(sof),
        .motion_detected(motion_detected), .threshold(threshold),
`ifdef MOTION_ROI_EN
        .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
`endif
        .motion_count(motion_count), .count_valid(count_valid),
        .motion_alarm(motion_alarm), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cv_seen = 0, fe_seen = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: frames as pixel index sequences, decided at frame end.
    int m_n, m_cnt, m_thr, m_streak, e_count;
    int rx0, rx1, ry0, ry1;
    bit m_in, m_rep, e_alarm, e_cv, e_fe;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in = 0; m_rep = 0; m_n = 0; m_cnt = 0; m_streak = 0;
            e_alarm = 0; e_cv = 0; e_fe = 0; e_count = 0;
        end else begin
            bit was_rep;
            int x, y;
            was_rep = m_rep; m_rep = 0; e_cv = 0; e_fe = 0;
            if (enable && sof) begin
                e_fe = m_in || was_rep;
                m_in = 1; m_n = 0; m_cnt = 0; m_thr = int'(threshold);
`ifdef MOTION_ROI_EN
                rx0 = int'(roi_x0); rx1 = int'(roi_x1);
                ry0 = int'(roi_y0); ry1 = int'(roi_y1);
`else
                rx0 = 0; rx1 = W - 1; ry0 = 0; ry1 = H - 1;
`endif
            end
            if (enable && m_in) begin
                x = m_n % W; y = m_n / W;
                if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1 &&
                    motion_detected && m_cnt < (1 << CW) - 1)
                    m_cnt++;
                m_n++;
                if (m_n == NPIX) begin
                    e_count = m_cnt; e_cv = 1; m_in = 0; m_rep = 1;
                    if (m_cnt >= m_thr) m_streak = (m_streak < AF) ? m_streak + 1 : AF;
                    else                m_streak = 0;
                    if (m_streak == AF)          e_alarm = 1;
                    else if (m_cnt < m_thr / 2)  e_alarm = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (count_valid === 1'b1) cv_seen++;
        if (frame_err === 1'b1)   fe_seen++;
        if (chk_on) begin
            chk("count_valid",  32'(count_valid),  32'(e_cv));
            chk("frame_err",    32'(frame_err),    32'(e_fe));
            chk("motion_alarm", 32'(motion_alarm), 32'(e_alarm));
            chk("motion_count", 32'(motion_count), 32'(e_count));
        end
    end

    task automatic px(input bit e, input bit s, input bit m);
        @(posedge clk);
        #1;
        enable = e; sof = s; motion_detected = m;
    endtask

    // Pixel i carries motion when (i*7)%32 < nmot: exactly nmot motion pixels
    // in a full frame, spread across it.
    task automatic frame(input int npix, input int nmot, input int maxgap, input bit tail);
        for (int i = 0; i < npix; i++) begin
            if (maxgap > 0)
                repeat ($urandom_range(0, maxgap)) px(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            px(1'b1, i == 0, ((i * 7) % 32) < nmot);
        end
        if (tail) px(1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cv0, fe0;
        #2 rst = 1'b0;
        #1;
        chk("rst_count", 32'(motion_count), 0);
        chk("rst_cv",    32'(count_valid), 0);
        chk("rst_alarm", 32'(motion_alarm), 0);
        chk("rst_fe",    32'(frame_err), 0);
        #20 rst = 1'b1;
        chk_on = 1'b1;

        repeat (5) px(1'b1, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b0);

        frame(NPIX, 12, 0, 1);
        settle();
        chk("f1_cv_next_cycle", 32'(count_valid), 1);
        chk("f1_count", 32'(motion_count), 12);
        chk("f1_alarm", 32'(motion_alarm), 0);

        frame(NPIX, 12, 0, 1);
        settle();
        chk("f2_alarm", 32'(motion_alarm), 0);
        frame(NPIX, 12, 0, 1);
        settle();
        chk("f3_alarm", 32'(motion_alarm), 1);
        frame(NPIX, 7, 0, 1);
        settle();
        chk("f7_count", 32'(motion_count), 7);
        chk("f7_alarm_hold", 32'(motion_alarm), 1);
        frame(NPIX, 4, 0, 1);
        settle();
        chk("f4_alarm_clear", 32'(motion_alarm), 0);

        cv0 = cv_seen; fe0 = fe_seen;
        frame(20, 30, 0, 1);
        frame(NPIX, 12, 0, 1);
        settle();
        chk("trunc_fe_pulses", 32'(fe_seen - fe0), 1);
        chk("trunc_cv_pulses", 32'(cv_seen - cv0), 1);
        chk("trunc_new_count", 32'(motion_count), 12);

        frame(NPIX, 12, 3, 1);
        settle();
        chk("gap_count", 32'(motion_count), 12);
        frame(NPIX, 12, 0, 1);
        settle();
        chk("pre_rst_alarm", 32'(motion_alarm), 1);

        frame(10, 12, 0, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_count", 32'(motion_count), 0);
        chk("midrst_cv",    32'(count_valid), 0);
        chk("midrst_alarm", 32'(motion_alarm), 0);
        chk("midrst_fe",    32'(frame_err), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        frame(NPIX, 12, 0, 1);
        settle();
        chk("postrst_count", 32'(motion_count), 12);
        chk("postrst_alarm", 32'(motion_alarm), 0);

        cv0 = cv_seen; fe0 = fe_seen;
        frame(NPIX, 12, 0, 0);
        frame(NPIX, 4, 0, 1);
        settle();
        chk("report_sof_fe", 32'(fe_seen - fe0), 1);
        chk("report_sof_cv", 32'(cv_seen - cv0), 2);
        chk("report_sof_count", 32'(motion_count), 4);

`ifdef MOTION_ROI_EN
        roi_x0 = 3'd2; roi_x1 = 3'd5; roi_y0 = 2'd1; roi_y1 = 2'd2;
        frame(NPIX, 32, 0, 1);
        settle();
        chk("roi_count", 32'(motion_count), 8);
        roi_x0 = 3'd6; roi_x1 = 3'd2;
        frame(NPIX, 32, 0, 1);
        settle();
        chk("roi_inverted", 32'(motion_count), 0);
`endif

        repeat (3) px(1'b0, 1'b0, 1'b0);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
